// File: rtl/twiddle_stage_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : twiddle_stage_scheduler_if
// Brief    : Butterfly/twiddle handshake bundle between scheduler and datapath.
// Revision : 1.0 - initial release
// ============================================================================
interface twiddle_stage_scheduler_if #(
  parameter int AW   = 6,
  parameter int SW   = 3,
  parameter int LOGN = 7
);
  logic            tw_valid;
  logic            tw_ready;
  logic [AW-1:0]   tw_addr;
  logic [SW-1:0]   stage;
  logic [LOGN-2:0] bfly_idx;
  logic            stage_last;

  modport master (
    output tw_valid, tw_addr, stage, bfly_idx, stage_last,
    input  tw_ready
  );

  modport slave (
    input  tw_valid, tw_addr, stage, bfly_idx, stage_last,
    output tw_ready
  );
endinterface
`default_nettype wire

// File: rtl/twiddle_stage_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : twiddle_stage_scheduler
// Brief    : Start-triggered, back-pressurable twiddle sequencer for a radix-2
//            DIF FFT, with a programmable drain gap between stages.
// Revision : 1.0 - initial release
// ============================================================================
module twiddle_stage_scheduler #(
  parameter int N    = 128,
  parameter int LOGN = 7,
  parameter int GAP  = 4,
  parameter int AW   = 6,
  parameter int SW   = 3
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  start,
  twiddle_stage_scheduler_if.master  tw,
  output logic                       busy,
  output logic                       frame_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int                c_GW         = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [c_GW-1:0]   c_GAP_LAST   = c_GW'((GAP > 0) ? (GAP - 1) : 0);
  localparam logic [LOGN-2:0]   c_BFLY_ONES  = {(LOGN-1){1'b1}};
  localparam logic [LOGN-2:0]   c_BFLY_ONE   = (LOGN-1)'(1);
  localparam logic [SW-1:0]     c_STAGE_LAST = SW'(LOGN - 1);
  localparam logic [SW-1:0]     c_STAGE_ONE  = SW'(1);

  state_t          r_state, w_state_nxt;
  logic [LOGN-2:0] r_bfly, w_bfly_nxt;
  logic [SW-1:0]   r_stage, w_stage_nxt;
  logic [c_GW-1:0] r_gap_cnt, w_gap_nxt;

  logic            w_hs;
  logic            w_bfly_last;
  logic            w_stage_final;
  logic [LOGN-2:0] w_j;

  assign w_hs          = (r_state == S_RUN) && tw.tw_ready;
  assign w_bfly_last   = (r_bfly == c_BFLY_ONES);
  assign w_stage_final = (r_stage == c_STAGE_LAST);

  // Half-group size is (N/2) >> stage, so its mask is the all-ones index shifted the same way.
  assign w_j = r_bfly & (c_BFLY_ONES >> r_stage);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_bfly    <= '0;
      r_stage   <= '0;
      r_gap_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_bfly    <= w_bfly_nxt;
      r_stage   <= w_stage_nxt;
      r_gap_cnt <= w_gap_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_bfly_nxt  = r_bfly;
    w_stage_nxt = r_stage;
    w_gap_nxt   = r_gap_cnt;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_bfly_nxt  = '0;
          w_stage_nxt = '0;
        end
      end
      S_RUN: begin
        if (w_hs) begin
          if (!w_bfly_last) begin
            w_bfly_nxt = r_bfly + c_BFLY_ONE;
          end else if (!w_stage_final) begin
            w_bfly_nxt  = '0;
            w_stage_nxt = r_stage + c_STAGE_ONE;
            if (GAP > 0) begin
              w_state_nxt = S_GAP;
              w_gap_nxt   = '0;
            end
          end else begin
            // Counters are parked at zero so IDLE presents all-zero outputs.
            w_state_nxt = S_DONE;
            w_bfly_nxt  = '0;
            w_stage_nxt = '0;
          end
        end
      end
      S_GAP: begin
        if (r_gap_cnt == c_GAP_LAST) begin
          w_state_nxt = S_RUN;
          w_gap_nxt   = '0;
        end else begin
          w_gap_nxt = r_gap_cnt + c_GW'(1);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    tw.tw_valid   = (r_state == S_RUN);
    tw.tw_addr    = AW'(w_j << r_stage);
    tw.stage      = r_stage;
    tw.bfly_idx   = r_bfly;
    tw.stage_last = (r_state == S_RUN) && w_bfly_last;
    busy          = (r_state != S_IDLE);
    frame_done    = (r_state == S_DONE);
  end

endmodule
`default_nettype wire

// File: tb/tb_twiddle_stage_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_twiddle_stage_scheduler
// Brief    : Scoreboard bench for twiddle_stage_scheduler (N=128/GAP=4 and N=8/GAP=0).
// Revision : 1.0 - initial release
// ============================================================================
module tb_twiddle_stage_scheduler;

  localparam int N = 128, LOGN = 7, GAP = 4, AW = 6, SW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic start8 = 1'b0;
  logic busy, frame_done, busy8, frame_done8;

  int total = 0, bad = 0;
  int q[$];
  int q8[$];
  int done_cnt = 0, exp_done = 0, done8_cnt = 0, exp_done8 = 0;
  int gap_run = 0, mon_exp = 0, mon8_exp = 0;
  int cyc8 = 0, last_hs8 = 0, hs8 = 0;
  int a8[12] = '{0, 1, 2, 3, 0, 2, 0, 2, 0, 0, 0, 0};
  int cyc;

  always #5 clk = ~clk;

  twiddle_stage_scheduler_if #(.AW(AW), .SW(SW), .LOGN(LOGN)) tif();
  twiddle_stage_scheduler_if #(.AW(2),  .SW(2),  .LOGN(3))    tif8();

  twiddle_stage_scheduler #(.N(N), .LOGN(LOGN), .GAP(GAP), .AW(AW), .SW(SW)) dut (
    .clk(clk), .rst(rst), .start(start), .tw(tif), .busy(busy), .frame_done(frame_done)
  );

  twiddle_stage_scheduler #(.N(8), .LOGN(3), .GAP(0), .AW(2), .SW(2)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .tw(tif8), .busy(busy8), .frame_done(frame_done8)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int pack(input int s, input int b, input int a, input int l);
    return (s << 16) | (b << 8) | (a << 1) | l;
  endfunction

  // Reference: the twiddle exponent is (b mod half-group) scaled by 2^stage.
  task automatic push_frame();
    for (int s = 0; s < LOGN; s++) begin
      for (int b = 0; b < N / 2; b++) begin
        int h = N / (2 ** (s + 1));
        q.push_back(pack(s, b, (b % h) * (2 ** s), (b == N / 2 - 1) ? 1 : 0));
      end
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, tif.tw_valid, 0);
    chk({tag, "_addr"},  tif.tw_addr, 0);
    chk({tag, "_stage"}, tif.stage, 0);
    chk({tag, "_bfly"},  tif.bfly_idx, 0);
    chk({tag, "_last"},  tif.stage_last, 0);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_done"},  frame_done, 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (tif.tw_valid && tif.tw_ready) begin
        if (q.size() == 0) chk("hs_unexpected", 1, 0);
        else begin
          mon_exp = q.pop_front();
          chk("hs_tuple", pack(int'(tif.stage), int'(tif.bfly_idx), int'(tif.tw_addr),
                               int'(tif.stage_last)), mon_exp);
        end
      end
      if (frame_done) begin
        done_cnt++;
        chk("hs_left_at_done", q.size(), 0);
      end
      if (!busy) gap_run = 0;
      else if (!tif.tw_valid && !frame_done) gap_run++;
      else if (tif.tw_valid) begin
        if (gap_run > 0) chk("gap_len", gap_run, GAP);
        gap_run = 0;
      end
    end
  end

  always @(negedge clk) begin
    cyc8++;
    if (!rst) begin
      if (tif8.tw_valid && tif8.tw_ready) begin
        if (q8.size() == 0) chk("d8_hs_unexpected", 1, 0);
        else begin
          mon8_exp = q8.pop_front();
          chk("d8_hs_tuple", pack(int'(tif8.stage), int'(tif8.bfly_idx), int'(tif8.tw_addr),
                                  int'(tif8.stage_last)), mon8_exp);
        end
        hs8++;
        last_hs8 = cyc8;
      end
      if (frame_done8) begin
        done8_cnt++;
        chk("d8_done_latency", cyc8 - last_hs8, 1);
        chk("d8_hs_count", hs8, 12);
        hs8 = 0;
      end
    end
  end

  task automatic run8(input bit do_stall);
    bit seen = 0;
    bit stalled = 0;
    for (int i = 0; i < 12; i++) q8.push_back(pack(i / 4, i % 4, a8[i], (i % 4 == 3) ? 1 : 0));
    exp_done8++;
    start8 = 1'b1;
    tif8.tw_ready = 1'b1;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk); #1;
      start8 = 1'b0;
      if (frame_done8) seen = 1;
      else if (do_stall && !stalled && tif8.stage == 2'd1 && tif8.bfly_idx == 2'd1) begin
        stalled = 1;
        tif8.tw_ready = 1'b0;
        repeat (3) begin
          @(posedge clk); #1;
          chk("stall_addr",  tif8.tw_addr, 2);
          chk("stall_stage", tif8.stage, 1);
          chk("stall_bfly",  tif8.bfly_idx, 1);
          chk("stall_valid", tif8.tw_valid, 1);
        end
        tif8.tw_ready = 1'b1;
      end
    end
    chk("d8_done_seen", seen, 1);
    if (do_stall) chk("d8_stall_hit", stalled, 1);
    @(posedge clk); #1;
    chk("d8_idle_after", busy8, 0);
  endtask

  task automatic run_frame(input int pct, input bit spam, output int ncyc);
    bit seen = 0;
    push_frame();
    exp_done++;
    start = 1'b1;
    tif.tw_ready = ($urandom_range(99) < pct);
    ncyc = 0;
    for (int i = 0; i < 5000 && !seen; i++) begin
      @(posedge clk); #1;
      ncyc++;
      start = spam ? 1'b1 : 1'b0;
      tif.tw_ready = ($urandom_range(99) < pct);
      if (frame_done) seen = 1;
    end
    if (!seen) chk("frame_timeout", 0, 1);
    // start may still be high during DONE; it must not launch another frame.
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_done", busy, 0);
    chk("done_one_cycle", frame_done, 0);
    @(posedge clk); #1;
    chk("stay_idle", busy, 0);
  endtask

  task automatic abort_frame();
    bit hit = 0;
    push_frame();
    start = 1'b1;
    for (int i = 0; i < 5000 && !hit; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      tif.tw_ready = 1'($urandom_range(1));
      if (tif.stage == 3'd3 && tif.bfly_idx == 6'd10) hit = 1;
    end
    chk("reached_stage3", hit, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_idle("after_rst");
    rst = 1'b0;
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("no_done_after_rst", done_cnt, exp_done);
    chk("idle_after_rst", busy, 0);
  endtask

  initial begin
    tif.tw_ready = 1'b0;
    tif8.tw_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle("reset");
    chk("reset8_valid", tif8.tw_valid, 0);
    chk("reset8_busy", busy8, 0);
    chk("reset8_done", frame_done8, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run8(1'b0);
    run8(1'b1);

    run_frame(100, 1'b0, cyc);
    chk("start_to_done_cycles", cyc, 473);
    run_frame(50, 1'b1, cyc);
    abort_frame();
    run_frame(50, 1'b0, cyc);
    run_frame(70, 1'b1, cyc);

    repeat (3) @(posedge clk);
    #1;
    chk("done_count", done_cnt, exp_done);
    chk("d8_done_count", done8_cnt, exp_done8);
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
